// File: rtl/ahb_cmd_master.sv
// Command-to-AHB-Lite master: one non-pipelined single transfer per command, response handshake back.
// Optional watchdog on HREADY-low stalls, enabled by defining AHB_CMD_MASTER_TIMEOUT_EN.
module ahb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        iClk,
    input  logic        iRsn,
    input  logic        iCmdValid,
    output logic        oCmdReady,
    input  logic        iCmdWrite,
    input  logic [31:0] iCmdAddr,
    input  logic [31:0] iCmdWdata,
    output logic        oRspValid,
    input  logic        iRspReady,
    output logic [31:0] oRspRdata,
    output logic        oRspErr,
    output logic        oRspTimeout,
    output logic        oHSEL,
    output logic [31:0] oHADDR,
    output logic [1:0]  oHTRANS,
    output logic        oHWRITE,
    output logic [31:0] oHWDATA,
    input  logic [31:0] iHRDATA,
    input  logic        iHREADY,
    input  logic [1:0]  iHRESP
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [31:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;

    // Transfers are always word-aligned, so the byte-lane bits are dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^iCmdAddr[1:0];

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt_q, cnt_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: if (iCmdValid) begin
                state_d = S_ADDR;
                write_d = iCmdWrite;
                addr_d  = iCmdAddr[31:2];
                wdata_d = iCmdWdata;
            end
            S_ADDR: if (iHREADY) state_d = S_DATA;
            // HRESP only counts on the completing cycle of a two-cycle ERROR.
            S_DATA: if (iHREADY) begin
                state_d = S_RESP;
                rdata_d = write_q ? 32'h0 : iHRDATA;
                err_d   = (iHRESP != 2'b00);
                tmo_d   = 1'b0;
            end
            S_RESP: if (iRspReady) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
        cnt_d = 8'h0;
        if ((state_q == S_ADDR || state_q == S_DATA) && !iHREADY) begin
            if (cnt_q + 8'd1 == TMO_LIMIT) begin
                state_d = S_RESP;
                rdata_d = 32'h0;
                err_d   = 1'b1;
                tmo_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) cnt_q <= 8'h0;
        else       cnt_q <= cnt_d;
    end
`endif

    // All outputs decode registered state, so they hold steady for the whole phase.
    always_comb begin
        oCmdReady   = 1'b0;
        oHSEL       = 1'b0;
        oHTRANS     = HTRANS_IDLE;
        oHADDR      = 32'h0;
        oHWRITE     = 1'b0;
        oHWDATA     = 32'h0;
        oRspValid   = 1'b0;
        oRspRdata   = 32'h0;
        oRspErr     = 1'b0;
        oRspTimeout = 1'b0;
        case (state_q)
            S_IDLE: oCmdReady = 1'b1;
            S_ADDR: begin
                oHSEL   = 1'b1;
                oHTRANS = HTRANS_NONSEQ;
                oHADDR  = {addr_q, 2'b00};
                oHWRITE = write_q;
            end
            S_DATA: begin
                oHADDR  = {addr_q, 2'b00};
                oHWRITE = write_q;
                oHWDATA = write_q ? wdata_q : 32'h0;
            end
            S_RESP: begin
                oRspValid   = 1'b1;
                oRspRdata   = rdata_q;
                oRspErr     = err_q;
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
                oRspTimeout = tmo_q;
`endif
            end
            default: ;
        endcase
    end

`ifndef AHB_CMD_MASTER_TIMEOUT_EN
    logic unused_tmo;
    assign unused_tmo = tmo_q;
`endif

endmodule
